// File: rtl/piso_shift_tx_pkg.sv
// Shared types and constants for the parallel-in serial-out frame transmitter.
// The PARITY state exists only when PISO_SHIFT_TX_PARITY_EN is defined.
package piso_shift_tx_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam logic        LINE_IDLE     = 1'b1;

`ifdef PISO_SHIFT_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_e;
`endif

  // Line level driven while the FSM sits in a given state (data/parity handled by caller).
  function automatic logic framing_level(input state_e st);
    return (st == ST_START) ? 1'b0 : LINE_IDLE;
  endfunction

endpackage

// File: rtl/dff_en_ar.sv
// Single-bit D flip-flop with clock enable and asynchronous active-high reset.
module dff_en_ar #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: start bit, WIDTH data bits LSB first, optional
// even parity (PISO_SHIFT_TX_PARITY_EN), stop bit; back-to-back loads accepted in STOP.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ser_d;
  logic             accept;
`ifdef PISO_SHIFT_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // Next-state, datapath and next-output decode; outputs are registered from next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
`ifdef PISO_SHIFT_TX_PARITY_EN
    par_d   = par_q;
`endif
    accept  = en && load_valid && ready_q;

    if (en) begin
      case (state_q)
        ST_IDLE, ST_STOP: begin
          if (accept) begin
            state_d = ST_START;
            shreg_d = data_in;
            cnt_d   = '0;
`ifdef PISO_SHIFT_TX_PARITY_EN
            par_d   = ^data_in;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: state_d = ST_DATA;
        ST_DATA: begin
          if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PISO_SHIFT_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end
`ifdef PISO_SHIFT_TX_PARITY_EN
        ST_PARITY: state_d = ST_STOP;
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    // Line level for the cycle that follows this edge.
    ser_d = framing_level(state_d);
    if (state_d == ST_DATA) begin
      ser_d = shreg_d[0];
    end
`ifdef PISO_SHIFT_TX_PARITY_EN
    if (state_d == ST_PARITY) begin
      ser_d = par_d;
    end
`endif

    ready_d = (state_d == ST_IDLE) || (state_d == ST_STOP);
    busy_d  = (state_d != ST_IDLE);
    done_d  = en && (state_d == ST_STOP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PISO_SHIFT_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  dff_en_ar #(
    .RST_VAL(LINE_IDLE)
  ) u_ser_ff (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .d    (ser_d),
    .q    (ser_out)
  );

  assign load_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
